// File: rtl/ifu_if.sv
// Fetch-unit bus: instruction memory request/response, decode-stage handoff,
// and the retire feedback (npc/halt) coming back from execute/writeback.
interface ifu_if;
  // Instruction memory request channel
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  // Instruction memory response channel
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  // Decode-stage handoff
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  // Retire feedback
  logic [31:0] npc;
  logic        npc_valid;
  logic        halt;
  // Fault status
  logic        misalign;

  // Fetch unit side
  modport master (
    output imem_req_valid,
    output imem_addr,
    output inst,
    output pc,
    output inst_valid,
    output misalign,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  inst_ready,
    input  npc,
    input  npc_valid,
    input  halt
  );

  // Memory / pipeline side
  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    input  inst,
    input  pc,
    input  inst_valid,
    input  misalign,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output inst_ready,
    output npc,
    output npc_valid,
    output halt
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one fetch in flight at a time, FETCH -> WAIT ->
// DELIVER -> EXEC loop, with an absorbing HALT on ebreak or misaligned npc.
module ifu #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter bit          PC_ALIGN_CHECK = 1'b1
) (
  input logic   clk,
  input logic   rst_n,
  ifu_if.master bus
);

  // One-hot encoded so exactly one state bit is ever set
  typedef enum logic [4:0] {
    StFetch   = 5'b00001,
    StWait    = 5'b00010,
    StDeliver = 5'b00100,
    StExec    = 5'b01000,
    StHalt    = 5'b10000
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        misalign_q, misalign_d;
  // Low through reset and until the first clock edge after release, so the
  // request cannot rise combinationally with rst_n deassertion.
  logic        started_q;

  // State and datapath registers, asynchronously reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0;
      misalign_q <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      misalign_q <= misalign_d;
      started_q  <= 1'b1;
    end
  end

  // Next-state logic; inputs not relevant to the current state are ignored
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    misalign_d = misalign_q;
    unique case (state_q)
      StFetch: begin
        if (started_q && bus.imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.imem_rsp_valid) begin
          inst_d  = bus.imem_rsp_data;
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        if (bus.inst_ready) begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (bus.npc_valid) begin
          if (bus.halt) begin
            state_d = StHalt;
          end else if (PC_ALIGN_CHECK && (bus.npc[1:0] != 2'b00)) begin
            // Faulting npc is dropped; pc keeps the last good address
            misalign_d = 1'b1;
            state_d    = StHalt;
          end else begin
            pc_d    = bus.npc;
            state_d = StFetch;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        // Corrupted encoding: park safely until reset
        state_d = StHalt;
      end
    endcase
  end

  // Outputs decode from registered state only
  always_comb begin
    bus.imem_req_valid = (state_q == StFetch) && started_q;
    bus.imem_addr      = pc_q;
    bus.inst_valid     = (state_q == StDeliver);
    bus.inst           = inst_q;
    bus.pc             = pc_q;
    bus.misalign       = misalign_q;
  end

endmodule
